// File: rtl/mem_to_apb_bridge.sv
// -----------------------------------------------------------------------------
// mem_to_apb_bridge
//
// Purpose:
//   Turns the word-oriented core request channel (req/gnt/rvalid) into single
//   APB3 transfers. Only one transfer is in flight at a time. Sub-word writes
//   are rejected without touching the bus, because APB3 has no write strobes.
//   A bus-hang timeout aborts an ACCESS phase whose slave never raises pready.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   data_req_i        request valid
//   data_addr_i       byte address (low two bits dropped on the APB side)
//   data_we_i         1 = write, 0 = read
//   data_be_i         byte enables (writes must be full-word)
//   data_wdata_i      write data
//   data_gnt_o        request accepted this cycle (combinational)
//   data_rvalid_o     one-cycle response strobe per granted request
//   data_rdata_o      read data, valid with data_rvalid_o, 0 otherwise
//   data_err_o        error flag, valid with data_rvalid_o, 0 otherwise
//   paddr_o, pwdata_o, pwrite_o, psel_o, penable_o   APB master outputs
//   prdata_i, pready_i, pslverr_i                    APB master inputs
// -----------------------------------------------------------------------------
module mem_to_apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,

    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Counter wide enough to hold TIMEOUT-1; a 1-bit stub when the timeout
    // is disabled or trivially short.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CNT_LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_INT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                  state_r;
    state_t                  state_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_s;
    logic                    latch_s;
    logic [DATA_WIDTH-1:0]   rdata_s;
    logic                    err_s;

    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic                    pwrite_r;
    logic                    psel_r;
    logic                    penable_r;
    logic                    rvalid_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    err_r;

    // Byte offset bits are intentionally dropped: APB transfers are word-aligned.
    logic                    unused_addr_s;
    assign unused_addr_s = ^data_addr_i[1:0];

    // Grant only when idle; everything else holds the requester off.
    assign data_gnt_o = data_req_i && (state_r == IDLE);

    // Next-state, counter and response-capture logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        latch_s = 1'b0;
        rdata_s = {DATA_WIDTH{1'b0}};
        err_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (data_req_i) begin
                    latch_s = 1'b1;
                    if (data_we_i && (data_be_i != 4'hF)) begin
                        // Partial write cannot be expressed on APB3: reject
                        // immediately without a bus cycle.
                        state_s = RESP;
                        err_s   = 1'b1;
                    end else begin
                        state_s = SETUP;
                        cnt_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            SETUP: begin
                state_s = ACCESS;
            end

            ACCESS: begin
                if (pready_i) begin
                    state_s = RESP;
                    rdata_s = pwrite_r ? {DATA_WIDTH{1'b0}} : prdata_i;
                    err_s   = pslverr_i;
                end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                    // Slave never answered: abort and report an error.
                    state_s = RESP;
                    err_s   = 1'b1;
                end else begin
                    state_s = ACCESS;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end

            RESP: begin
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter and registered bus/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            paddr_r   <= {ADDR_WIDTH{1'b0}};
            pwdata_r  <= {DATA_WIDTH{1'b0}};
            pwrite_r  <= 1'b0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            // Request fields are captured only on grant so they stay stable
            // from SETUP through the end of ACCESS.
            if (latch_s) begin
                paddr_r  <= {data_addr_i[ADDR_WIDTH-1:2], 2'b00};
                pwdata_r <= data_wdata_i;
                pwrite_r <= data_we_i;
            end else begin
                paddr_r  <= paddr_r;
                pwdata_r <= pwdata_r;
                pwrite_r <= pwrite_r;
            end
            // Bus controls are decoded from the next state so they are glitch-free
            // registers aligned with the state they describe.
            psel_r    <= (state_s == SETUP) || (state_s == ACCESS);
            penable_r <= (state_s == ACCESS);
            rvalid_r  <= (state_s == RESP);
            rdata_r   <= rdata_s;
            err_r     <= err_s;
        end
    end

    assign paddr_o       = paddr_r;
    assign pwdata_o      = pwdata_r;
    assign pwrite_o      = pwrite_r;
    assign psel_o        = psel_r;
    assign penable_o     = penable_r;
    assign data_rvalid_o = rvalid_r;
    assign data_rdata_o  = rdata_r;
    assign data_err_o    = err_r;

endmodule

// File: tb/tb_mem_to_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_mem_to_apb_bridge
//
// Directed bench for mem_to_apb_bridge built with TIMEOUT=4. Each task drives a
// short cycle-indexed scenario; inputs are applied 1 time unit after the rising
// edge and outputs are compared 1 more unit later, well away from the edge.
// -----------------------------------------------------------------------------
module tb_mem_to_apb_bridge;

    logic        clk;
    logic        rst;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    int total;
    int bad;

    mem_to_apb_bridge #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_req_i    (data_req_i),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pwrite_o      (pwrite_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .prdata_i      (prdata_i),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        data_req_i   = 1'b0;
        data_addr_i  = 32'h0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_wdata_i = 32'h0;
        prdata_i     = 32'h0;
        pready_i     = 1'b0;
        pslverr_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1;
        total++;
        if ({psel_o, penable_o, pwrite_o, data_rvalid_o, data_err_o, data_gnt_o} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {psel_o, penable_o, pwrite_o, data_rvalid_o, data_err_o, data_gnt_o});
        end
        total++;
        if ({paddr_o, pwdata_o, data_rdata_o} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want all 0",
                     paddr_o, pwdata_o, data_rdata_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait_read();
        for (int c = 0; c <= 4; c++) begin
            data_req_i  = (c == 0);
            data_addr_i = 32'h1A10_3004;
            data_we_i   = 1'b0;
            data_be_i   = 4'h0;
            pready_i    = (c == 2);
            prdata_i    = (c == 2) ? 32'hCAFE_F00D : 32'h1111_1111;
            #1;
            total++;
            if (data_gnt_o !== (c == 0)) begin
                bad++;
                $display("FAIL zw_read_gnt c=%0d: got %b want %b", c, data_gnt_o, (c == 0));
            end
            total++;
            if ({psel_o, penable_o} !== {(c >= 1 && c <= 2), (c == 2)}) begin
                bad++;
                $display("FAIL zw_read_psel_pen c=%0d: got %b%b", c, psel_o, penable_o);
            end
            total++;
            if (data_rvalid_o !== (c == 3)) begin
                bad++;
                $display("FAIL zw_read_rvalid c=%0d: got %b want %b", c, data_rvalid_o, (c == 3));
            end
            if (c == 1) begin
                total++;
                if (paddr_o !== 32'h1A10_3004 || pwrite_o !== 1'b0) begin
                    bad++;
                    $display("FAIL zw_read_addr: paddr=%h pwrite=%b want 1a103004 0", paddr_o, pwrite_o);
                end
            end
            total++;
            if (data_rdata_o !== ((c == 3) ? 32'hCAFE_F00D : 32'h0) || data_err_o !== 1'b0) begin
                bad++;
                $display("FAIL zw_read_rdata c=%0d: rdata=%h err=%b", c, data_rdata_o, data_err_o);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_write_wait_states();
        for (int c = 0; c <= 7; c++) begin
            data_req_i   = (c == 0);
            data_addr_i  = 32'h1A10_1007;
            data_we_i    = 1'b1;
            data_be_i    = 4'hF;
            data_wdata_i = (c == 0) ? 32'h1234_5678 : 32'hFFFF_0000;
            pready_i     = (c == 5);
            prdata_i     = 32'hDEAD_BEEF;
            #1;
            total++;
            if ({psel_o, penable_o} !== {(c >= 1 && c <= 5), (c >= 2 && c <= 5)}) begin
                bad++;
                $display("FAIL wr_wait_psel_pen c=%0d: got %b%b", c, psel_o, penable_o);
            end
            if (c >= 1 && c <= 5) begin
                total++;
                if (paddr_o !== 32'h1A10_1004 || pwdata_o !== 32'h1234_5678 || pwrite_o !== 1'b1) begin
                    bad++;
                    $display("FAIL wr_wait_stable c=%0d: paddr=%h pwdata=%h pwrite=%b want 1a101004 12345678 1",
                             c, paddr_o, pwdata_o, pwrite_o);
                end
            end
            total++;
            if (data_rvalid_o !== (c == 6)) begin
                bad++;
                $display("FAIL wr_wait_rvalid c=%0d: got %b want %b", c, data_rvalid_o, (c == 6));
            end
            total++;
            if (data_rdata_o !== 32'h0 || data_err_o !== 1'b0) begin
                bad++;
                $display("FAIL wr_wait_resp c=%0d: rdata=%h err=%b want 0 0", c, data_rdata_o, data_err_o);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_partial_write();
        for (int c = 0; c <= 3; c++) begin
            data_req_i   = (c == 0);
            data_addr_i  = 32'h1A10_2000;
            data_we_i    = 1'b1;
            data_be_i    = 4'b0011;
            data_wdata_i = 32'hAAAA_5555;
            pready_i     = 1'b1;
            prdata_i     = 32'h7777_7777;
            #1;
            total++;
            if (psel_o !== 1'b0 || penable_o !== 1'b0) begin
                bad++;
                $display("FAIL partial_wr_nobus c=%0d: psel=%b penable=%b want 0 0", c, psel_o, penable_o);
            end
            total++;
            if (data_rvalid_o !== (c == 1) || data_err_o !== (c == 1)) begin
                bad++;
                $display("FAIL partial_wr_resp c=%0d: rvalid=%b err=%b want %b %b",
                         c, data_rvalid_o, data_err_o, (c == 1), (c == 1));
            end
            total++;
            if (data_rdata_o !== 32'h0) begin
                bad++;
                $display("FAIL partial_wr_rdata c=%0d: got %h want 0", c, data_rdata_o);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_slave_error();
        for (int c = 0; c <= 4; c++) begin
            data_req_i  = (c == 0);
            data_addr_i = 32'h1A10_4008;
            data_we_i   = 1'b0;
            data_be_i   = 4'hF;
            pready_i    = (c == 2);
            pslverr_i   = (c == 2);
            prdata_i    = (c == 2) ? 32'h55AA_1234 : 32'hFFFF_FFFF;
            #1;
            total++;
            if (data_rvalid_o !== (c == 3)) begin
                bad++;
                $display("FAIL slverr_rvalid c=%0d: got %b want %b", c, data_rvalid_o, (c == 3));
            end
            total++;
            if (data_err_o !== (c == 3) || data_rdata_o !== ((c == 3) ? 32'h55AA_1234 : 32'h0)) begin
                bad++;
                $display("FAIL slverr_resp c=%0d: err=%b rdata=%h", c, data_err_o, data_rdata_o);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        for (int c = 0; c <= 11; c++) begin
            data_req_i  = (c == 0) || (c == 6) || (c == 7);
            data_addr_i = (c == 0) ? 32'h1A10_5000 : 32'h1A10_6000;
            data_we_i   = 1'b0;
            data_be_i   = 4'hF;
            pready_i    = (c == 9);
            prdata_i    = 32'h0BAD_F00D;
            #1;
            total++;
            if (data_gnt_o !== (c == 0 || c == 7)) begin
                bad++;
                $display("FAIL timeout_gnt c=%0d: got %b want %b", c, data_gnt_o, (c == 0 || c == 7));
            end
            total++;
            if ({psel_o, penable_o} !== {((c >= 1 && c <= 5) || c == 8 || c == 9),
                                         ((c >= 2 && c <= 5) || c == 9)}) begin
                bad++;
                $display("FAIL timeout_psel_pen c=%0d: got %b%b", c, psel_o, penable_o);
            end
            total++;
            if (data_rvalid_o !== (c == 6 || c == 10) || data_err_o !== (c == 6)) begin
                bad++;
                $display("FAIL timeout_resp c=%0d: rvalid=%b err=%b", c, data_rvalid_o, data_err_o);
            end
            total++;
            if (data_rdata_o !== ((c == 10) ? 32'h0BAD_F00D : 32'h0)) begin
                bad++;
                $display("FAIL timeout_rdata c=%0d: got %h", c, data_rdata_o);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 11; c++) begin
            data_req_i  = (c <= 8);
            data_addr_i = 32'h1A10_7000;
            data_we_i   = 1'b0;
            data_be_i   = 4'hF;
            pready_i    = 1'b1;
            prdata_i    = 32'h1000_0000 + 32'(c);
            #1;
            total++;
            if (data_gnt_o !== (c % 4 == 0 && c <= 8)) begin
                bad++;
                $display("FAIL b2b_gnt c=%0d: got %b", c, data_gnt_o);
            end
            total++;
            if (data_rvalid_o !== (c % 4 == 3)) begin
                bad++;
                $display("FAIL b2b_rvalid c=%0d: got %b", c, data_rvalid_o);
            end
            if (c % 4 == 3) begin
                total++;
                if (data_rdata_o !== 32'h1000_0000 + 32'(c - 1)) begin
                    bad++;
                    $display("FAIL b2b_rdata c=%0d: got %h want %h", c, data_rdata_o, 32'h1000_0000 + 32'(c - 1));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        for (int c = 0; c <= 8; c++) begin
            rst          = (c == 2);
            data_req_i   = (c == 0) || (c == 4);
            data_addr_i  = (c == 0) ? 32'h1A10_8000 : 32'h1A10_900C;
            data_we_i    = (c == 0);
            data_be_i    = 4'hF;
            data_wdata_i = 32'hA5A5_A5A5;
            pready_i     = (c == 6);
            prdata_i     = (c == 6) ? 32'h600D_CAFE : 32'h0;
            #1;
            if (c == 2) begin
                total++;
                if (psel_o !== 1'b1 || pwdata_o !== 32'hA5A5_A5A5) begin
                    bad++;
                    $display("FAIL rst_mid_pre: psel=%b pwdata=%h want 1 a5a5a5a5", psel_o, pwdata_o);
                end
            end
            if (c == 3) begin
                total++;
                if ({psel_o, penable_o, pwrite_o, data_rvalid_o, data_err_o} !== 5'b0 ||
                    {paddr_o, pwdata_o, data_rdata_o} !== 96'h0) begin
                    bad++;
                    $display("FAIL rst_mid_clear: psel=%b pen=%b pwrite=%b rvalid=%b paddr=%h pwdata=%h",
                             psel_o, penable_o, pwrite_o, data_rvalid_o, paddr_o, pwdata_o);
                end
            end
            if (c >= 3) begin
                total++;
                if (data_gnt_o !== (c == 4) || data_rvalid_o !== (c == 7)) begin
                    bad++;
                    $display("FAIL rst_mid_after c=%0d: gnt=%b rvalid=%b", c, data_gnt_o, data_rvalid_o);
                end
                total++;
                if (psel_o !== (c == 5 || c == 6)) begin
                    bad++;
                    $display("FAIL rst_mid_psel c=%0d: got %b", c, psel_o);
                end
            end
            if (c == 5) begin
                total++;
                if (paddr_o !== 32'h1A10_900C || pwrite_o !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_mid_addr: paddr=%h pwrite=%b want 1a10900c 0", paddr_o, pwrite_o);
                end
            end
            if (c == 7) begin
                total++;
                if (data_rdata_o !== 32'h600D_CAFE || data_err_o !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_mid_rdata: rdata=%h err=%b want 600dcafe 0", data_rdata_o, data_err_o);
                end
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_zero_wait_read();
        test_write_wait_states();
        test_partial_write();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_to_apb_bridge.md
Name: mem_to_apb_bridge

Overview:
- Converts the core/interconnect word-oriented request channel (req/gnt/rvalid) into single APB3 transfers that drive the peripheral APB bus.
- Sits directly upstream of the peripheral APB bus: its APB outputs connect to an APB_BUS Master modport, which the address decoder then fans out to the nine peripheral slaves.
- One transfer in flight at a time.
- Adds a bus-hang timeout and rejects sub-word writes, because APB3 has no strobes.

Parameters:
- ADDR_WIDTH, 32, width of data_addr_i and paddr_o.
- DATA_WIDTH, 32, width of the read and write data paths. Fixed at 32; the byte-enable checks assume 4 lanes.
- TIMEOUT, 256, number of ACCESS cycles to wait for pready before aborting. 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- data_req_i  input  1  request valid.
- data_addr_i  input  ADDR_WIDTH  byte address.
- data_we_i  input  1  1 = write, 0 = read.
- data_be_i  input  4  byte enables.
- data_wdata_i  input  DATA_WIDTH  write data.
- data_gnt_o  output  1  request accepted this cycle.
- data_rvalid_o  output  1  response valid, asserted for exactly one cycle per granted request.
- data_rdata_o  output  DATA_WIDTH  read data, valid while data_rvalid_o is high.
- data_err_o  output  1  error flag, valid while data_rvalid_o is high.
- paddr_o  output  ADDR_WIDTH  APB address.
- pwdata_o  output  DATA_WIDTH  APB write data.
- pwrite_o  output  1  APB write.
- psel_o  output  1  APB select.
- penable_o  output  1  APB enable.
- prdata_i  input  DATA_WIDTH  APB read data.
- pready_i  input  1  APB ready.
- pslverr_i  input  1  APB slave error.

Behaviour:
- State machine states: IDLE, SETUP, ACCESS, RESP.
- Reset: when rst is sampled high, the next state is IDLE and every output is 0. This includes paddr_o, pwdata_o, data_rdata_o and the timeout counter. Reset mid-transfer abandons the transfer with no rvalid; psel_o drops in the same edge.
- Grant: data_gnt_o = data_req_i AND state==IDLE (combinational). No grant in any other state; requests are held off until the block returns to IDLE.
- IDLE, on grant, latches the request:
  - paddr_o = {addr[ADDR_WIDTH-1:2], 2'b00}, pwrite_o = we, pwdata_o = wdata.
  - If we=1 and be!=4'hF, the write is rejected: go to RESP with err=1 and rdata=0. No APB cycle is issued (psel_o stays 0).
  - Otherwise go to SETUP. Reads ignore be.
- SETUP: psel_o=1, penable_o=0 for exactly one cycle, then ACCESS.
- ACCESS: psel_o=1, penable_o=1.
  - If pready_i is sampled 1: capture rdata = (pwrite ? 0 : prdata_i) and err = pslverr_i, go to RESP. psel_o and penable_o are 0 on the next cycle.
  - Else increment the timeout counter. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with pready still 0, abort: go to RESP with err=1 and rdata=0. psel_o and penable_o are deasserted.
- RESP: data_rvalid_o=1 for one cycle with the captured rdata and err, then IDLE. data_rdata_o and data_err_o return to 0 outside RESP.
- Address, write data and pwrite are stable from SETUP through the end of ACCESS, as APB requires. The counter clears on entry to SETUP.
- Latency: grant at cycle 0 gives SETUP at 1, ACCESS at 2, RESP at 3 when pready is 1 on the first ACCESS cycle. Each wait state adds 1 cycle. A rejected write gives rvalid at cycle 1.
- Back-to-back: the earliest next grant is the cycle after RESP, i.e. 4 cycles per zero-wait transfer.
- pslverr_i and prdata_i are ignored except in the ACCESS cycle where pready_i=1.

Test Plan:
- Zero-wait read at 0x1A10_3004, slave returns 0xCAFE_F00D with pready=1 on the first ACCESS cycle -> gnt at cycle 0; psel at cycles 1–2; penable at cycle 2; rvalid at cycle 3 with rdata 0xCAFEF00D and err=0.
- Write 0x1234_5678 to address 0x1A10_1007 with be=F and 3 wait states -> paddr_o=0x1A10_1004 and pwdata stable across cycles 1–5; rvalid at cycle 6 with err=0 and rdata=0.
- Write with be=4'b0011 -> no psel at any point; rvalid at cycle 1 with err=1.
- Read where the slave returns pslverr=1 together with pready=1 -> rvalid with err=1 and rdata=prdata.
- TIMEOUT=4, pready held at 0 -> ACCESS lasts 4 cycles; psel drops; rvalid with err=1 and rdata=0; a following request is granted the cycle after.
- rst asserted during ACCESS, then a new read -> all outputs 0 after the edge and no rvalid for the aborted transfer; the new read completes with normal 3-cycle latency.
